if_id_buffer: RTL and testbench

- Fetch-to-decode pipeline buffer: captures each instruction/PC pair from the fetch stage and presents it to decode with a valid/ready handshake.
- Small FIFO (DEPTH entries) absorbs decode stalls without dropping fetched words.
- Flush input discards all buffered instructions on a taken branch/jump.

---
 rtl/if_id_buffer_if.sv | 37 +++
 rtl/if_id_buffer.sv | 97 +++++++++
 tb/tb_if_id_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID pipeline buffer.
//   slave  : buffer side. It receives the fetch word, flush and dec_ready,
//            and drives fetch_ready plus the decode head outputs.
//   master : environment side (fetch + decode), the mirror of slave.
// Signals:
//   fetch_valid/fetch_instruction/fetch_pc/fetch_ready : fetch handshake
//   flush                                              : discard all words
//   dec_valid/dec_ready/dec_instruction/dec_pc/
//   dec_pc_plus4/dec_illegal                           : decode handshake
interface if_id_buffer_if #(
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ADDRESS     = 32
);
  logic                   fetch_valid;
  logic [INSTRUCTION-1:0] fetch_instruction;
  logic [ADDRESS-1:0]     fetch_pc;
  logic                   fetch_ready;
  logic                   flush;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [INSTRUCTION-1:0] dec_instruction;
  logic [ADDRESS-1:0]     dec_pc;
  logic [ADDRESS-1:0]     dec_pc_plus4;
  logic                   dec_illegal;

  modport slave (
    input  fetch_valid, fetch_instruction, fetch_pc, flush, dec_ready,
    output fetch_ready, dec_valid, dec_instruction, dec_pc, dec_pc_plus4,
           dec_illegal
  );

  modport master (
    output fetch_valid, fetch_instruction, fetch_pc, flush, dec_ready,
    input  fetch_ready, dec_valid, dec_instruction, dec_pc, dec_pc_plus4,
           dec_illegal
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a DEPTH-entry FIFO of (instruction, pc) pairs
// between fetch and decode with valid/ready handshakes on both sides.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (wins over flush)
//   bus  : if_id_buffer_if.slave (fetch word in, decode head out, flush)
// Head outputs come only from storage: a word pushed at one edge is seen
// by decode after that edge, never in the same cycle.
// Optional macro IF_ID_ILLEGAL_CHECK_EN: store a per-entry flag marking
// words that are all-zero or lack the 2'b11 uncompressed opcode suffix,
// reported on dec_illegal. Without it dec_illegal is tied to 0.
module if_id_buffer #(
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ADDRESS     = 32,
  parameter int unsigned DEPTH       = 2
) (
  input logic           clk,
  input logic           rst,
  if_id_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [INSTRUCTION-1:0] NOP = INSTRUCTION'(32'h0000_0013);

  logic [INSTRUCTION-1:0] instr_mem [DEPTH];
  logic [ADDRESS-1:0]     pc_mem    [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   not_full;
  logic                   not_empty;
  logic                   push;
  logic                   pop;
  logic [ADDRESS-1:0]     head_pc;

  // Readiness depends on occupancy only, so a pop never frees a slot for a
  // push in the same cycle.
  assign not_full  = count < CNT_W'(DEPTH);
  assign not_empty = count != '0;
  assign push      = bus.fetch_valid & not_full & ~bus.flush;
  assign pop       = not_empty & bus.dec_ready & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= bus.fetch_instruction;
      pc_mem[tail]    <= bus.fetch_pc;
    end
  end

`ifdef IF_ID_ILLEGAL_CHECK_EN
  logic [DEPTH-1:0] ill_mem;
  logic             head_ill;

  always_ff @(posedge clk) begin
    if (push) begin
      ill_mem[tail] <= (bus.fetch_instruction[1:0] != 2'b11) |
                       (bus.fetch_instruction == '0);
    end
  end

  assign head_ill = ill_mem[head];
`else
  logic head_ill;
  assign head_ill = 1'b0;
`endif

  always_comb begin
    bus.fetch_ready     = not_full;
    bus.dec_valid       = not_empty;
    bus.dec_instruction = NOP;
    head_pc             = '0;
    bus.dec_illegal     = 1'b0;
    if (not_empty) begin
      bus.dec_instruction = instr_mem[head];
      head_pc             = pc_mem[head];
      bus.dec_illegal     = head_ill;
    end
    bus.dec_pc       = head_pc;
    bus.dec_pc_plus4 = head_pc + ADDRESS'(4);
  end
endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_buffer_if #(.INSTRUCTION(32), .ADDRESS(32)) bus ();

  if_id_buffer #(
    .INSTRUCTION(32),
    .ADDRESS(32),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fi;
    logic [31:0] fp;
    logic        fl;
    logic        dr;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] e4;
    logic        er;
  } vec_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;

  vec_t tbl[$];
  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic fv, logic [31:0] fi, logic [31:0] fp,
                              logic fl, logic dr, logic ev, logic [31:0] ei,
                              logic [31:0] ep, logic [31:0] e4, logic er);
    vec_t v;
    v.rst = r; v.fv = fv; v.fi = fi; v.fp = fp; v.fl = fl; v.dr = dr;
    v.ev = ev; v.ei = ei; v.ep = ep; v.e4 = e4; v.er = er;
    return v;
  endfunction

  function automatic vec_t mk_empty(logic r, logic fv, logic [31:0] fi,
                                    logic [31:0] fp, logic fl, logic dr);
    return mk(r, fv, fi, fp, fl, dr, 1'b0, NOP, 32'h0, 32'h4, 1'b1);
  endfunction

  function automatic logic exp_ill(logic [31:0] ins);
`ifdef IF_ID_ILLEGAL_CHECK_EN
    return (ins[1:0] != 2'b11) || (ins == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Scoreboard step for the inputs currently driven, applied before the edge.
  task automatic model_step(logic r, logic fv, logic [31:0] fi, logic [31:0] fp,
                            logic fl, logic dr);
    bit   acc;
    bit   pop;
    ent_t e;
    acc = fv && (sb.size() < DEPTH);
    pop = (sb.size() != 0) && dr;
    if (r || fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        e.i = fi;
        e.p = fp;
        sb.push_back(e);
      end
    end
  endtask

  task automatic sb_compare(int step);
    ent_t h;
    if (sb.size() != 0) begin
      h = sb[0];
      chk("sb_valid", step, 32'(bus.dec_valid), 32'd1);
      chk("sb_instr", step, bus.dec_instruction, h.i);
      chk("sb_pc", step, bus.dec_pc, h.p);
      chk("sb_illegal", step, 32'(bus.dec_illegal), 32'(exp_ill(h.i)));
    end else begin
      chk("sb_valid", step, 32'(bus.dec_valid), 32'd0);
      chk("sb_illegal", step, 32'(bus.dec_illegal), 32'd0);
    end
    chk("sb_fetch_ready", step, 32'(bus.fetch_ready), 32'(sb.size() < DEPTH));
  endtask

  task automatic drive(logic r, logic fv, logic [31:0] fi, logic [31:0] fp,
                       logic fl, logic dr);
    rst                   = r;
    bus.fetch_valid       = fv;
    bus.fetch_instruction = fi;
    bus.fetch_pc          = fp;
    bus.flush             = fl;
    bus.dec_ready         = dr;
    model_step(r, fv, fi, fp, fl, dr);
  endtask

  initial begin
    logic [31:0] ri;
    logic [31:0] rp;
    // Reset held two cycles with fetch_valid high.
    tbl.push_back(mk_empty(1, 1, 32'h1111_1113, 32'h100, 0, 0));
    tbl.push_back(mk_empty(1, 1, 32'h1111_1113, 32'h100, 0, 0));
    // Streaming with decode always ready.
    tbl.push_back(mk(0, 1, 32'h0050_0093, 32'h0, 0, 1, 1, 32'h0050_0093, 32'h0, 32'h4, 1));
    tbl.push_back(mk(0, 1, 32'h00A0_0113, 32'h4, 0, 1, 1, 32'h00A0_0113, 32'h4, 32'h8, 1));
    tbl.push_back(mk(0, 1, 32'h0020_81B3, 32'h8, 0, 1, 1, 32'h0020_81B3, 32'h8, 32'hC, 1));
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));
    // Stall: two accepted, third held while full, then drain.
    tbl.push_back(mk(0, 1, 32'h0010_0093, 32'h10, 0, 0, 1, 32'h0010_0093, 32'h10, 32'h14, 1));
    tbl.push_back(mk(0, 1, 32'h0020_0113, 32'h14, 0, 0, 1, 32'h0010_0093, 32'h10, 32'h14, 0));
    tbl.push_back(mk(0, 1, 32'h0030_0193, 32'h18, 0, 0, 1, 32'h0010_0093, 32'h10, 32'h14, 0));
    tbl.push_back(mk(0, 1, 32'h0030_0193, 32'h18, 0, 1, 1, 32'h0020_0113, 32'h14, 32'h18, 1));
    tbl.push_back(mk(0, 1, 32'h0030_0193, 32'h18, 0, 1, 1, 32'h0030_0193, 32'h18, 32'h1C, 1));
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));
    // Flush while full with a word offered and decode ready.
    tbl.push_back(mk(0, 1, 32'h0040_0213, 32'h20, 0, 0, 1, 32'h0040_0213, 32'h20, 32'h24, 1));
    tbl.push_back(mk(0, 1, 32'h0050_0293, 32'h24, 0, 0, 1, 32'h0040_0213, 32'h20, 32'h24, 0));
    tbl.push_back(mk_empty(0, 1, 32'h0060_0313, 32'h28, 1, 1));
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));
    // PC wrap on the +4 output.
    tbl.push_back(mk(0, 1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 0, 1, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 1));
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));
    // Illegal-flag candidates (flag checked through the scoreboard).
    tbl.push_back(mk(0, 1, 32'h0000_0000, 32'h40, 0, 0, 1, 32'h0000_0000, 32'h40, 32'h44, 1));
    tbl.push_back(mk(0, 1, 32'h0000_0092, 32'h44, 0, 1, 1, 32'h0000_0092, 32'h44, 32'h48, 1));
    tbl.push_back(mk(0, 1, 32'h0000_0013, 32'h48, 0, 1, 1, 32'h0000_0013, 32'h48, 32'h4C, 1));
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));
    // Reset wins over flush.
    tbl.push_back(mk(0, 1, 32'h0070_0393, 32'h50, 0, 0, 1, 32'h0070_0393, 32'h50, 32'h54, 1));
    tbl.push_back(mk_empty(1, 1, 32'h0080_0413, 32'h54, 1, 0));
    // Ten streaming cycles to walk the pointers around several times.
    for (int i = 0; i < 10; i++) begin
      ri = 32'h0000_0013 | (32'(i + 1) << 20);
      rp = 32'h200 + 32'(4 * i);
      tbl.push_back(mk(0, 1, ri, rp, 0, 1, 1, ri, rp, rp + 32'h4, 1));
    end
    tbl.push_back(mk_empty(0, 0, 32'h0, 32'h0, 0, 1));

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].rst, tbl[n].fv, tbl[n].fi, tbl[n].fp, tbl[n].fl, tbl[n].dr);
      @(posedge clk);
      #1;
      chk("dec_valid", n, 32'(bus.dec_valid), 32'(tbl[n].ev));
      chk("dec_instruction", n, bus.dec_instruction, tbl[n].ei);
      chk("dec_pc", n, bus.dec_pc, tbl[n].ep);
      chk("dec_pc_plus4", n, bus.dec_pc_plus4, tbl[n].e4);
      chk("fetch_ready", n, 32'(bus.fetch_ready), 32'(tbl[n].er));
      sb_compare(n);
    end

    // Random traffic, checked against the scoreboard only.
    for (int n = 0; n < 120; n++) begin
      ri = $urandom;
      rp = $urandom & 32'hFFFF_FFFC;
      drive(1'b0, 1'($urandom_range(0, 3) != 0), ri, rp,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      @(posedge clk);
      #1;
      sb_compare(1000 + n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
